uart_bus_bridge: RTL
====================

// Module: uart_bus_bridge
// PURPOSE
// - Host-side bus master driven by the serial link: parses command bytes from the UART receiver,
//   issues single bus reads/writes, and returns responses through the UART transmitter.
// - Sits between the receiver/transmitter drivers and the Wishbone-style bus, in the slave's place.
// - Used for debug load/peek of memory and peripherals without the CPU.
// PARAMETERS
// - ADDR_W     32      bus address width; must be a multiple of 8
// - DATA_W     32      bus data width; must be a multiple of 8
// - TIMEOUT    1023    ack wait limit in cycles; used only with UART_BRIDGE_TIMEOUT_EN
// PORTS
// - clk           in   1       single system clock; all logic on rising edge
// - rst           in   1       synchronous, active-high reset
// - rx_data_i     in   8       received byte; valid only while rx_valid_i=1
// - rx_valid_i    in   1       one-cycle strobe per received byte
// - tx_data_o     out  8       byte to transmit; stable from tx_start_o until tx_busy_i falls
// - tx_start_o    out  1       one-cycle start pulse to the transmitter
// - tx_busy_i     in   1       transmitter busy; rises the cycle after tx_start_o
// - bus_addr_o    out  ADDR_W  bus address
// - bus_data_o    out  DATA_W  bus write data
// - bus_data_i    in   DATA_W  bus read data; sampled on the bus_ack_i cycle
// - bus_select_o  out  1       bus cycle request; held until ack (or timeout)
// - bus_we_o      out  1       1=write, 0=read; valid with bus_select_o
// - bus_ack_i     in   1       slave acknowledge
// - busy_o        out  1       1 in every state except IDLE
// - rx_drop_o     out  1       one-cycle pulse: rx byte discarded (arrived in BUS or RESP)
// BEHAVIOUR
// - Reset: all outputs 0; state=IDLE; byte counter=0; address/data registers=0.
// - Frames: 'W'(0x57) + ADDR_W/8 address bytes + DATA_W/8 data bytes, or 'R'(0x52) + address bytes.
//   Multi-byte fields are sent MSB first.
// - Any other byte seen in IDLE is ignored silently. No rx_drop_o pulse is generated for it.
// - States and transitions:
//   IDLE  --'W'/'R'--> ADDR; latch the command.
//   ADDR  --last addr byte--> WDATA (write) or BUS (read).
//   WDATA --last data byte--> BUS.
//   BUS: assert bus_select_o and bus_we_o in the cycle after the last byte.
//        On bus_ack_i, deassert both in the next cycle.
//        Read: latch bus_data_i. Then go to RESP.
//   RESP: write returns 'K'(0x4B); read returns DATA_W/8 bytes, MSB first. Then IDLE.
// - Shifting: each accepted rx byte shifts into the LSB of the field register, which shifts left by 8.
//   The byte counter runs modulo field bytes, counts from 0, and resets on every state change.
// - TX handshake:
//   - Raise tx_start_o only when tx_busy_i=0 and no start was issued in the previous cycle.
//   - Next byte only after tx_busy_i is seen 1 and then 0.
// - rx_valid_i in BUS or RESP: the byte is dropped and rx_drop_o pulses. State is unaffected.
// - rx_valid_i and the final ack in the same cycle: the ack is processed and the byte is dropped.
// - bus_ack_i outside BUS is ignored.
// - rst mid-operation: immediate return to IDLE, outputs cleared.
//   A byte already being shifted out by the transmitter is not recalled.
// - Throughput: one bus transaction per frame. No pipelining and no queuing.
// CONFIGURATION
// - UART_BRIDGE_TIMEOUT_EN defined:
//   - A cycle counter runs in BUS. After TIMEOUT cycles without ack, drop bus_select_o.
//   - Reply 0xEE (single byte, both commands), then go to IDLE.
// - UART_BRIDGE_TIMEOUT_EN undefined: BUS waits for ack indefinitely. The timeout counter is not built.
// TESTING
// - Write: rx 57 00 00 10 00 DE AD BE EF -> one bus cycle:
//   addr=0x00001000, data=0xDEADBEEF, we=1; ack after 3 cycles -> tx 0x4B once.
// - Read: rx 52 00 00 20 04; slave acks with 0x12345678 -> we=0, addr=0x00002004;
//   tx 12,34,56,78 in order, each start only after busy 1->0.
// - Junk: rx 00 FF 41 then a valid read frame -> junk ignored; the read completes normally.
// - Drop: a byte arrives during BUS wait -> rx_drop_o pulses 1 cycle; the response is unchanged.
// - Reset: assert rst after 3 address bytes -> IDLE, all outputs 0;
//   a following full write frame executes correctly.
// - Timeout (macro defined, TIMEOUT=15): read with ack never driven ->
//   select falls after 15 cycles; tx 0xEE; without the macro, select stays high.

Source files
------------

// File: rtl/uart_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_bridge
// Description : Serial-command bus master. Parses 'W'/'R' frames from the
//               UART receiver, runs one bus cycle, replies via the transmitter.
//               Optional ack timeout: define UART_BRIDGE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic [7:0]        tx_data_o,
   output logic              tx_start_o,
   input  logic              tx_busy_i,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_data_o,
   input  logic [DATA_W-1:0] bus_data_i,
   output logic              bus_select_o,
   output logic              bus_we_o,
   input  logic              bus_ack_i,
   output logic              busy_o,
   output logic              rx_drop_o
);

   localparam int         c_cnt_w      = 8;
   localparam int         c_addr_bytes = ADDR_W / 8;
   localparam int         c_data_bytes = DATA_W / 8;
   localparam logic [7:0] c_cmd_write  = 8'h57;
   localparam logic [7:0] c_cmd_read   = 8'h52;
   localparam logic [7:0] c_rsp_ok     = 8'h4B;
   localparam logic [7:0] c_rsp_tmo    = 8'hEE;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADDR  = 3'd1,
      S_WDATA = 3'd2,
      S_BUS   = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_cnt_w-1:0]   r_cnt;
   logic                 r_is_write;
   logic                 r_timed_out;
   logic [ADDR_W-1:0]    r_addr;
   logic [DATA_W-1:0]    r_data;
   logic                 r_sel;
   logic                 r_we;
   logic [7:0]           r_tx_data;
   logic                 r_tx_start;
   logic                 r_tx_pending;
   logic                 r_tx_seen;
   logic                 r_rx_drop;

   logic                 w_is_cmd;
   logic                 w_addr_last;
   logic                 w_data_last;
   logic                 w_resp_last;
   logic                 w_tx_done;
   logic                 w_cnt_inc;
   logic                 w_timeout;
   logic [7:0]           w_resp_byte;

`ifdef UART_BRIDGE_TIMEOUT_EN
   localparam int c_to_w = $clog2(TIMEOUT + 1);
   logic [c_to_w-1:0] r_to_cnt;

   always_ff @(posedge clk) begin
      if (rst || r_state != S_BUS) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state == S_BUS) && !bus_ack_i &&
                      (r_to_cnt == c_to_w'(TIMEOUT - 1));
`else
   logic [31:0] w_unused_timeout;
   assign w_unused_timeout = TIMEOUT;
   assign w_timeout        = 1'b0;
`endif

   assign w_is_cmd    = (rx_data_i == c_cmd_write) || (rx_data_i == c_cmd_read);
   assign w_addr_last = (r_cnt == c_cnt_w'(c_addr_bytes - 1));
   assign w_data_last = (r_cnt == c_cnt_w'(c_data_bytes - 1));
   assign w_tx_done   = r_tx_pending && r_tx_seen && !tx_busy_i;
   assign w_resp_last = (r_timed_out || r_is_write) ? 1'b1 : w_data_last;
   assign w_cnt_inc   = (((r_state == S_ADDR) || (r_state == S_WDATA)) && rx_valid_i) ||
                        ((r_state == S_RESP) && w_tx_done);

   // Read data is shifted left after each byte, so the MSB byte is always next.
   assign w_resp_byte = r_timed_out ? c_rsp_tmo :
                        r_is_write  ? c_rsp_ok  : r_data[DATA_W-1 -: 8];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (rx_valid_i && w_is_cmd) w_state_nxt = S_ADDR;
         end
         S_ADDR: begin
            if (rx_valid_i && w_addr_last) w_state_nxt = r_is_write ? S_WDATA : S_BUS;
         end
         S_WDATA: begin
            if (rx_valid_i && w_data_last) w_state_nxt = S_BUS;
         end
         S_BUS: begin
            if (bus_ack_i || w_timeout) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (w_tx_done && w_resp_last) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_is_write   <= 1'b0;
         r_timed_out  <= 1'b0;
         r_addr       <= '0;
         r_data       <= '0;
         r_sel        <= 1'b0;
         r_we         <= 1'b0;
         r_tx_data    <= '0;
         r_tx_start   <= 1'b0;
         r_tx_pending <= 1'b0;
         r_tx_seen    <= 1'b0;
         r_rx_drop    <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         r_rx_drop  <= rx_valid_i && ((r_state == S_BUS) || (r_state == S_RESP));

         if (w_state_nxt != r_state) begin
            r_cnt <= '0;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (rx_valid_i && w_is_cmd) begin
                  r_is_write  <= (rx_data_i == c_cmd_write);
                  r_timed_out <= 1'b0;
               end
            end
            S_ADDR: begin
               if (rx_valid_i) begin
                  r_addr <= (r_addr << 8) | ADDR_W'(rx_data_i);
                  if (w_addr_last && !r_is_write) begin
                     r_sel <= 1'b1;
                     r_we  <= 1'b0;
                  end
               end
            end
            S_WDATA: begin
               if (rx_valid_i) begin
                  r_data <= (r_data << 8) | DATA_W'(rx_data_i);
                  if (w_data_last) begin
                     r_sel <= 1'b1;
                     r_we  <= 1'b1;
                  end
               end
            end
            S_BUS: begin
               if (bus_ack_i) begin
                  r_sel <= 1'b0;
                  r_we  <= 1'b0;
                  if (!r_is_write) r_data <= bus_data_i;
               end else if (w_timeout) begin
                  r_sel       <= 1'b0;
                  r_we        <= 1'b0;
                  r_timed_out <= 1'b1;
               end
            end
            S_RESP: begin
               if (!r_tx_pending) begin
                  if (!tx_busy_i && !r_tx_start) begin
                     r_tx_start   <= 1'b1;
                     r_tx_data    <= w_resp_byte;
                     r_tx_pending <= 1'b1;
                     r_tx_seen    <= 1'b0;
                  end
               end else begin
                  if (tx_busy_i) r_tx_seen <= 1'b1;
                  if (w_tx_done) begin
                     r_tx_pending <= 1'b0;
                     if (!r_is_write && !r_timed_out) r_data <= r_data << 8;
                  end
               end
            end
            default: begin
               r_sel <= 1'b0;
               r_we  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_data_o    = r_tx_data;
   assign tx_start_o   = r_tx_start;
   assign bus_addr_o   = r_addr;
   assign bus_data_o   = r_data;
   assign bus_select_o = r_sel;
   assign bus_we_o     = r_we;
   assign busy_o       = (r_state != S_IDLE);
   assign rx_drop_o    = r_rx_drop;

endmodule
`default_nettype wire
